// File: rtl/mem_wb_stage.sv
// mem_wb_stage: multi-channel MEM/WB register with skid buffer, flush, zero-address gating; MEM_WB_FWD_EN adds forwarding lookup
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_CH = 2,
  parameter logic [NUM_CH-1:0] ZERO_MASK = 2'b01
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*ADDR_W-1:0] mem_wd,
  input  logic [NUM_CH-1:0]        mem_wreg,
  input  logic [NUM_CH*DATA_W-1:0] mem_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*ADDR_W-1:0] wb_wd,
  output logic [NUM_CH-1:0]        wb_wreg,
  output logic [NUM_CH*DATA_W-1:0] wb_wdata,
`ifdef MEM_WB_FWD_EN
  input  logic [ADDR_W-1:0]        fwd_raddr,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data,
`endif
  output logic [15:0]              stall_cnt
);
  logic main_v, skid_v, in_x, out_x;
  logic [NUM_CH-1:0] main_wreg, skid_wreg, gated;
  logic [NUM_CH*ADDR_W-1:0] skid_wd;
  logic [NUM_CH*DATA_W-1:0] skid_wdata;
  assign in_ready = ~skid_v;
  assign out_valid = main_v;
  assign wb_wreg = main_v ? main_wreg : '0;
  assign in_x = in_valid & ~skid_v;
  assign out_x = main_v & out_ready;
  always_comb begin
    gated = '0;
    for (int c = 0; c < NUM_CH; c++)
      gated[c] = mem_wreg[c] & ~(ZERO_MASK[c] & (mem_wd[c*ADDR_W +: ADDR_W] == '0));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      wb_wd <= '0;
      main_wreg <= '0;
      wb_wdata <= '0;
      skid_wd <= '0;
      skid_wreg <= '0;
      skid_wdata <= '0;
      stall_cnt <= '0;
    end else begin
      if (main_v && !out_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (flush) begin
        main_v <= 1'b0;
        skid_v <= 1'b0;
      end else if (out_x) begin
        if (skid_v) begin
          wb_wd <= skid_wd;
          main_wreg <= skid_wreg;
          wb_wdata <= skid_wdata;
          skid_v <= 1'b0;
        end else if (in_x) begin
          wb_wd <= mem_wd;
          main_wreg <= gated;
          wb_wdata <= mem_wdata;
        end else main_v <= 1'b0;
      end else if (in_x) begin
        if (main_v) begin
          skid_wd <= mem_wd;
          skid_wreg <= gated;
          skid_wdata <= mem_wdata;
          skid_v <= 1'b1;
        end else begin
          wb_wd <= mem_wd;
          main_wreg <= gated;
          wb_wdata <= mem_wdata;
          main_v <= 1'b1;
        end
      end
    end
  end
`ifdef MEM_WB_FWD_EN
  // later assignments win: skid beats main, lower channel beats higher
  always_comb begin
    fwd_hit = 1'b0;
    fwd_data = '0;
    for (int c = NUM_CH - 1; c >= 0; c--)
      if (main_v && main_wreg[c] && wb_wd[c*ADDR_W +: ADDR_W] == fwd_raddr) begin
        fwd_hit = 1'b1;
        fwd_data = wb_wdata[c*DATA_W +: DATA_W];
      end
    for (int c = NUM_CH - 1; c >= 0; c--)
      if (skid_v && skid_wreg[c] && skid_wd[c*ADDR_W +: ADDR_W] == fwd_raddr) begin
        fwd_hit = 1'b1;
        fwd_data = skid_wdata[c*DATA_W +: DATA_W];
      end
  end
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed plus random stimulus against a queue-based reference model
module tb_mem_wb_stage;
  localparam int DW = 32, AW = 5, NC = 2;
  localparam logic [NC-1:0] ZM = 2'b01;
  typedef struct {
    logic [NC*AW-1:0] wd;
    logic [NC-1:0]    wreg;
    logic [NC*DW-1:0] data;
  } b_t;
  logic clk = 1'b0, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [NC*AW-1:0] mem_wd, wb_wd;
  logic [NC-1:0] mem_wreg, wb_wreg;
  logic [NC*DW-1:0] mem_wdata, wb_wdata;
  logic [15:0] stall_cnt;
`ifdef MEM_WB_FWD_EN
  logic [AW-1:0] fwd_raddr;
  logic fwd_hit;
  logic [DW-1:0] fwd_data;
`endif
  always #5 clk = ~clk;
  mem_wb_stage #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC), .ZERO_MASK(ZM)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
    .wb_wdata(wb_wdata),
`ifdef MEM_WB_FWD_EN
    .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
`endif
    .stall_cnt(stall_cnt));
  int checks = 0, failures = 0;
  b_t q[$];
  b_t last;
  int unsigned cnt;
  logic [AW-1:0] fr = 7;
  function automatic logic [NC-1:0] gate(logic [NC*AW-1:0] wd, logic [NC-1:0] wreg);
    logic [NC-1:0] g;
    for (int c = 0; c < NC; c++) g[c] = wreg[c] && !(ZM[c] && wd[c*AW +: AW] == 0);
    return g;
  endfunction
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic push(logic [AW-1:0] a0, logic [AW-1:0] a1, logic [NC-1:0] en, logic [NC*DW-1:0] d);
    in_valid = 1'b1;
    mem_wd = {a1, a0};
    mem_wreg = en;
    mem_wdata = d;
  endtask
  task automatic step();
    int pre;
    logic ix, ox;
    pre = q.size();
    ix = in_valid && pre < 2;
    ox = out_ready && pre > 0;
`ifdef MEM_WB_FWD_EN
    fwd_raddr = fr;
`endif
    @(posedge clk);
    if (rst) begin
      q.delete();
      cnt = 0;
      last = '{default: '0};
    end else begin
      if (pre > 0 && !out_ready && cnt < 16'hFFFF) cnt++;
      if (flush) q.delete();
      else begin
        if (ox) void'(q.pop_front());
        if (ix) q.push_back('{mem_wd, gate(mem_wd, mem_wreg), mem_wdata});
      end
    end
    if (q.size() > 0) last = q[0];
    @(negedge clk);
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("wb_wreg", wb_wreg, q.size() > 0 ? last.wreg : '0);
    chk("wb_wd", wb_wd, last.wd);
    chk("wb_wdata", wb_wdata, last.data);
    chk("stall_cnt", stall_cnt, cnt);
`ifdef MEM_WB_FWD_EN
    begin
      logic h;
      logic [DW-1:0] d;
      h = 1'b0;
      d = '0;
      for (int j = q.size() - 1; j >= 0 && !h; j--)
        for (int c = 0; c < NC && !h; c++)
          if (q[j].wreg[c] && q[j].wd[c*AW +: AW] == fr) begin
            h = 1'b1;
            d = q[j].data[c*DW +: DW];
          end
      chk("fwd_hit", fwd_hit, h);
      chk("fwd_data", fwd_data, d);
    end
`endif
  endtask
  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    push(5'd4, 5'd6, 2'b11, 64'h1234_5678_9ABC_DEF0);
    step();
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    push(5'd3, 5'd1, 2'b01, {32'h0, 32'hDEAD0001});
    step();
    chk("stream_wd0", wb_wd[4:0], 5'd3);
    chk("stream_data0", wb_wdata[31:0], 32'hDEAD0001);
    for (int i = 0; i < 4; i++) begin
      push(5'(i + 8), 5'(i), 2'b11, {$urandom, $urandom});
      step();
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    push(5'd7, 5'd2, 2'b01, {32'h0, 32'd5});
    step();
    push(5'd7, 5'd3, 2'b01, {32'h0, 32'd9});
    step();
    push(5'd9, 5'd4, 2'b11, {32'hC, 32'hC});
    step();
    chk("bp_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    in_valid = 1'b0;
    step();
    push(5'd0, 5'd0, 2'b11, {$urandom, $urandom});
    step();
    chk("zero_sup", wb_wreg, 2'b10);
    out_ready = 1'b0;
    push(5'd11, 5'd12, 2'b11, {$urandom, $urandom});
    step();
    flush = 1'b1;
    step();
    chk("flush_valid", out_valid, 1'b0);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 3000; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 24) == 0;
      rst = $urandom_range(0, 299) == 0;
      for (int c = 0; c < NC; c++) mem_wd[c*AW +: AW] = 5'($urandom_range(0, 7));
      mem_wreg = 2'($urandom);
      mem_wdata = {$urandom, $urandom};
      fr = 5'($urandom_range(0, 7));
      step();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 65540; i++) step();
    chk("stall_sat", stall_cnt, 16'hFFFF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Parametrised MEM/WB pipeline register, successor to the fixed single-channel latch. Carries NUM_CH independent register-write channels (e.g. GPR plus HI/LO) from the memory stage to writeback. Uses a valid/ready handshake with a 2-entry skid buffer, synchronous flush, write-enable gating and a stall counter. Sits between the memory-access stage and the register file and HI/LO unit.

Parameters:
DATA_W, 32, width of each channel's write data
ADDR_W, 5, width of each channel's destination address
NUM_CH, 2, number of write channels, 1..4
ZERO_MASK, 2'b01, NUM_CH bits; bit i set means channel i suppresses writes to address 0

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  synchronous pipeline flush, active-high
in_valid  input  1  memory stage presents a bundle
in_ready  output  1  stage can accept a bundle
mem_wd  input  NUM_CH*ADDR_W  per-channel destination address; channel i at [i*ADDR_W +: ADDR_W]
mem_wreg  input  NUM_CH  per-channel write enable
mem_wdata  input  NUM_CH*DATA_W  per-channel write data
out_valid  output  1  writeback bundle valid
out_ready  input  1  writeback consumer accepts the bundle
wb_wd  output  NUM_CH*ADDR_W  registered addresses
wb_wreg  output  NUM_CH  registered enables, gated
wb_wdata  output  NUM_CH*DATA_W  registered data
stall_cnt  output  16  saturating count of back-pressure cycles

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset, checked on the clk edge with rst=1: out_valid=0, wb_wd=0, wb_wreg=0, wb_wdata=0, stall_cnt=0, skid empty. in_ready=1 on the first cycle after reset.
- Storage: main register drives the outputs; one skid register. State is one of EMPTY, ONE (main full), TWO (main and skid full).
- in_ready is registered and equals "skid empty". It never depends combinationally on out_ready.
- An input transfer occurs when in_valid and in_ready are both 1. An output transfer occurs when out_valid and out_ready are both 1.
- EMPTY: an input transfer loads main and goes to ONE. Latency from input transfer to out_valid is 1 cycle.
- ONE, output transfer with no input transfer: go to EMPTY.
- ONE, input transfer with output transfer: main is reloaded and the state stays ONE.
- ONE, input transfer with no output transfer: the bundle goes to skid, the state goes to TWO, and in_ready drops next cycle.
- TWO, output transfer: skid moves to main and the state goes to ONE. No input transfer is possible in TWO.
- Order is strictly preserved. No bundle is dropped or duplicated except on flush.
- Gating on load: wb_wreg[i] = mem_wreg[i] & ~(ZERO_MASK[i] & (mem_wd[i]==0)). Address and data are still registered as given.
- When out_valid=0, wb_wreg is forced to all zero. wb_wd and wb_wdata hold their last values.
- Flush: on the next edge, main and skid are invalidated, the state goes to EMPTY and in_ready goes to 1. An input transfer in the flush cycle is discarded. stall_cnt is unaffected.
- Priority: rst > flush > normal operation.
- stall_cnt increments each cycle with out_valid=1 and out_ready=0. It saturates at 16'hFFFF and is cleared only by rst.
- No arithmetic is applied to the data path. Widths are passed through unchanged.

Optional Feature:
- Macro: MEM_WB_FWD_EN.
- When defined, the block adds three ports: fwd_raddr (input, ADDR_W), fwd_hit (output, 1) and fwd_data (output, DATA_W).
- These form a combinational forwarding lookup for the decode stage. The lookup searches the skid first, then main, in channel-0-first order. It matches only valid entries whose gated wreg is 1 and whose address equals fwd_raddr. fwd_hit=0 and fwd_data=0 on a miss.
- When not defined, these ports and their logic are absent. The rest of the behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> out_valid=0, wb_wreg=0, stall_cnt=0; in_ready=1 after release.
- Streaming: NUM_CH=2, out_ready=1; push {ch0: wd=3, wreg=1, data=32'hDEAD0001} -> one cycle later out_valid=1, wb_wd[4:0]=3, wb_wdata[31:0]=32'hDEAD0001; back-to-back pushes give one output per cycle.
- Back-pressure: hold out_ready=0 and push 3 bundles A,B,C -> A and B accepted, in_ready=0 on the third cycle; stall_cnt counts each stalled cycle; releasing out_ready yields A then B in order, then C is accepted.
- Zero suppression: ZERO_MASK=2'b01, ch0 wd=0 wreg=1, ch1 wd=0 wreg=1 -> wb_wreg=2'b10.
- Flush in TWO state with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed bundles never appear at the output.
- With MEM_WB_FWD_EN defined: main holds ch0 wd=7 data=5 and skid holds ch0 wd=7 data=9; fwd_raddr=7 -> fwd_hit=1, fwd_data=9.
